// File: rtl/exe_logic_issue_pkg.sv
// Shared execute-stage definitions for the logic-unit issue buffer.
// Holds operand/address widths, buffer depth, one-hot logic op codes,
// the buffered entry layout and the op normalisation helper.
package exe_logic_issue_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int DEPTH   = 2;

  localparam logic [2:0] LOGIC_AND = 3'b001;
  localparam logic [2:0] LOGIC_OR  = 3'b010;
  localparam logic [2:0] LOGIC_XOR = 3'b100;

  typedef struct packed {
    logic [2:0]         op;
    logic [XLEN-1:0]    s1;
    logic [XLEN-1:0]    s2;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic               s2_imm;
    logic [RADDR_W-1:0] rd;
  } entry_t;

  // Multi-hot decode output collapses to the lowest set bit so the logic
  // unit always sees a clean one-hot (or all-zero) select.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    logic [2:0] r;
    r = 3'b000;
    if (op[0])      r = LOGIC_AND;
    else if (op[1]) r = LOGIC_OR;
    else if (op[2]) r = LOGIC_XOR;
    return r;
  endfunction

endpackage

// File: rtl/exe_logic_issue_if.sv
// Decode-to-issue, writeback-bypass and issue-to-logic-unit signal bundle.
// slave  : the issue buffer (consumes in_*/byp_*/out_ready_i, drives the rest).
// master : the surrounding pipeline (decode, writeback, logic unit).
interface exe_logic_issue_if;
  import exe_logic_issue_pkg::*;

  logic               in_valid_i;
  logic               in_ready_o;
  logic [2:0]         in_op_i;
  logic [XLEN-1:0]    in_s1_i;
  logic [XLEN-1:0]    in_s2_i;
  logic [RADDR_W-1:0] in_rs1_i;
  logic [RADDR_W-1:0] in_rs2_i;
  logic               in_s2_imm_i;
  logic [RADDR_W-1:0] in_rd_i;

  logic               byp_valid_i;
  logic [RADDR_W-1:0] byp_rd_i;
  logic [XLEN-1:0]    byp_data_i;

  logic               out_valid_o;
  logic               out_ready_i;
  logic [2:0]         out_op_o;
  logic [XLEN-1:0]    out_s1_o;
  logic [XLEN-1:0]    out_s2_o;
  logic [RADDR_W-1:0] out_rd_o;

  modport slave (
    input  in_valid_i, in_op_i, in_s1_i, in_s2_i, in_rs1_i, in_rs2_i,
           in_s2_imm_i, in_rd_i, byp_valid_i, byp_rd_i, byp_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_op_o, out_s1_o, out_s2_o, out_rd_o
  );

  modport master (
    output in_valid_i, in_op_i, in_s1_i, in_s2_i, in_rs1_i, in_rs2_i,
           in_s2_imm_i, in_rd_i, byp_valid_i, byp_rd_i, byp_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_op_o, out_s1_o, out_s2_o, out_rd_o
  );

endinterface

// File: rtl/exe_byp_match.sv
// Writeback-bypass select for one source operand; purely combinational.
// Ports: byp_valid/byp_rd from writeback, rs/imm of the operand, sel = take byp data.
// x0 and immediates never match.
module exe_byp_match
  import exe_logic_issue_pkg::*;
(
  input  logic               byp_valid,
  input  logic [RADDR_W-1:0] byp_rd,
  input  logic [RADDR_W-1:0] rs,
  input  logic               imm,
  output logic               sel
);

  assign sel = byp_valid && !imm && (rs != '0) && (byp_rd == rs);

endmodule

// File: rtl/exe_logic_issue.sv
// Two-entry skid buffer in front of the execute logic unit, patching operands from writeback bypass.
// Latency: push at cycle N visible at output N+1 when empty; sustains one push + one pop per cycle.
// Backpressure: in_ready_o = not full, from registered count only; flush/reset drop all entries.
// Ports: clk, rst (sync active-high), flush_i, bus (slave modport: in_*, byp_*, out_*).
module exe_logic_issue
  import exe_logic_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  exe_logic_issue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  entry_t           mem [DEPTH];

  logic   push;
  logic   pop;
  logic   in_s1_sel;
  logic   in_s2_sel;
  entry_t in_entry;

  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_s1_sel;
  logic [DEPTH-1:0] ent_s2_sel;

  assign bus.in_ready_o  = (count != CNT_W'(DEPTH));
  assign bus.out_valid_o = (count != '0);

  assign push = bus.in_valid_i && bus.in_ready_o && !flush_i;
  assign pop  = bus.out_valid_o && bus.out_ready_i && !flush_i;

  // Bypass on the incoming op: the register file value read at decode may
  // already be stale by the writeback happening this very cycle.
  exe_byp_match u_in_s1 (
    .byp_valid (bus.byp_valid_i),
    .byp_rd    (bus.byp_rd_i),
    .rs        (bus.in_rs1_i),
    .imm       (1'b0),
    .sel       (in_s1_sel)
  );

  exe_byp_match u_in_s2 (
    .byp_valid (bus.byp_valid_i),
    .byp_rd    (bus.byp_rd_i),
    .rs        (bus.in_rs2_i),
    .imm       (bus.in_s2_imm_i),
    .sel       (in_s2_sel)
  );

  always_comb begin
    in_entry.op     = norm_op(bus.in_op_i);
    in_entry.s1     = in_s1_sel ? bus.byp_data_i : bus.in_s1_i;
    in_entry.s2     = in_s2_sel ? bus.byp_data_i : bus.in_s2_i;
    in_entry.rs1    = bus.in_rs1_i;
    in_entry.rs2    = bus.in_rs2_i;
    in_entry.s2_imm = bus.in_s2_imm_i;
    in_entry.rd     = bus.in_rd_i;
  end

  // Held entries keep listening to writeback until they leave the buffer.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] ofs;

    // Slot i is occupied when its distance from the head is below count.
    assign ofs        = PTR_W'(i) - rd_ptr;
    assign ent_vld[i] = CNT_W'(ofs) < count;

    exe_byp_match u_s1 (
      .byp_valid (bus.byp_valid_i),
      .byp_rd    (bus.byp_rd_i),
      .rs        (mem[i].rs1),
      .imm       (1'b0),
      .sel       (ent_s1_sel[i])
    );

    exe_byp_match u_s2 (
      .byp_valid (bus.byp_valid_i),
      .byp_rd    (bus.byp_rd_i),
      .rs        (mem[i].rs2),
      .imm       (mem[i].s2_imm),
      .sel       (ent_s2_sel[i])
    );
  end

  // Payload is not reset; outputs are masked while the buffer is empty.
  // A push only targets a free slot, so it never collides with a bypass
  // patch of a held entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr == PTR_W'(i))) begin
        mem[i] <= in_entry;
      end else begin
        if (ent_vld[i] && ent_s1_sel[i]) mem[i].s1 <= bus.byp_data_i;
        if (ent_vld[i] && ent_s2_sel[i]) mem[i].s2 <= bus.byp_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is presented straight from storage; nothing from in_* reaches here.
  assign bus.out_op_o = bus.out_valid_o ? mem[rd_ptr].op : '0;
  assign bus.out_s1_o = bus.out_valid_o ? mem[rd_ptr].s1 : '0;
  assign bus.out_s2_o = bus.out_valid_o ? mem[rd_ptr].s2 : '0;
  assign bus.out_rd_o = bus.out_valid_o ? mem[rd_ptr].rd : '0;

endmodule
